pipelined_shifter: RTL and testbench

PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

---
 rtl/shifter_pkg.sv | 27 ++
 rtl/shift_stage.sv | 109 ++++++++++
 rtl/pipelined_shifter.sv | 83 ++++++++
 tb/tb_pipelined_shifter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Holds the operation encodings and the elaboration-time helpers.
package shifter_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
        case (op)
            OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the shifter: applies amount bits [LVL_LO, LVL_HI)
// and holds the partial result with a local valid/ready handshake.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = 5,
    parameter int LVL_LO     = 0,
    parameter int LVL_HI     = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [SHAMT_W-1:0]    in_shamt,
    input  logic [2:0]            in_op,
    input  logic                  in_sign,
    input  logic                  in_illegal,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [SHAMT_W-1:0]    out_shamt,
    output logic [2:0]            out_op,
    output logic                  out_sign,
    output logic                  out_illegal
);

    function automatic logic [DATA_WIDTH-1:0] shift_by(
        input logic [DATA_WIDTH-1:0] x,
        input logic [2:0]            op,
        input logic                  sign,
        input int                    amt
    );
        case (op)
            OP_SLL:  return x << amt;
            OP_SRL:  return x >> amt;
            OP_SRA:  return (x >> amt) | ({DATA_WIDTH{sign}} << (DATA_WIDTH - amt));
            OP_ROL:  return (x << amt) | (x >> (DATA_WIDTH - amt));
            OP_ROR:  return (x >> amt) | (x << (DATA_WIDTH - amt));
            default: return x;
        endcase
    endfunction

    // Each level conditionally shifts by a fixed power of two, LSB level first.
    logic [DATA_WIDTH-1:0] lvl [LVL_LO:LVL_HI];
    assign lvl[LVL_LO] = in_data;

    for (genvar j = LVL_LO; j < LVL_HI; j++) begin : g_level
        assign lvl[j+1] = in_shamt[j] ? shift_by(lvl[j], in_op, in_sign, 1 << j) : lvl[j];
    end

    logic                  valid_q,   valid_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic [SHAMT_W-1:0]    shamt_q,   shamt_d;
    logic [2:0]            op_q,      op_d;
    logic                  sign_q,    sign_d;
    logic                  illegal_q, illegal_d;
    logic                  load;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        shamt_d   = shamt_q;
        op_d      = op_q;
        sign_d    = sign_q;
        illegal_d = illegal_q;
        if (in_ready) valid_d = in_valid;
        if (load) begin
            data_d    = lvl[LVL_HI];
            shamt_d   = in_shamt;
            op_d      = in_op;
            sign_d    = in_sign;
            illegal_d = in_illegal;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the data
    // registers are reset too because the output must read zero during reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            shamt_q   <= '0;
            op_q      <= '0;
            sign_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            shamt_q   <= shamt_d;
            op_q      <= op_d;
            sign_q    <= sign_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_shamt   = shamt_q;
    assign out_op      = op_q;
    assign out_sign    = sign_q;
    assign out_illegal = illegal_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready on both sides.
// A chain of shift_stage instances each resolves LEVELS_PER_STAGE amount bits.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int LEVELS_PER_STAGE = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            Shiftop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  out_illegal
);

    localparam int SHAMT_W    = clog2(DATA_WIDTH);
    localparam int NUM_STAGES = (SHAMT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    logic                  valid_s   [NUM_STAGES+1];
    logic                  ready_s   [NUM_STAGES+1];
    logic [DATA_WIDTH-1:0] data_s    [NUM_STAGES+1];
    logic [SHAMT_W-1:0]    shamt_s   [NUM_STAGES+1];
    logic [2:0]            op_s      [NUM_STAGES+1];
    logic                  sign_s    [NUM_STAGES+1];
    logic                  illegal_s [NUM_STAGES+1];
    logic                  in_illegal;

    // An illegal op enters as zero data; every stage then shifts zeros harmlessly.
    assign in_illegal   = !op_is_legal(Shiftop);
    assign valid_s[0]   = in_valid;
    assign in_ready     = ready_s[0];
    assign data_s[0]    = in_illegal ? '0 : A;
    assign shamt_s[0]   = B[SHAMT_W-1:0];
    assign op_s[0]      = Shiftop;
    assign sign_s[0]    = A[DATA_WIDTH-1];
    assign illegal_s[0] = in_illegal;

    assign ready_s[NUM_STAGES] = out_ready;
    assign out_valid           = valid_s[NUM_STAGES];
    assign Result              = data_s[NUM_STAGES];
    assign out_illegal         = illegal_s[NUM_STAGES];

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int LO = k * LEVELS_PER_STAGE;
        localparam int HI = ((k + 1) * LEVELS_PER_STAGE > SHAMT_W) ? SHAMT_W
                                                                   : (k + 1) * LEVELS_PER_STAGE;
        shift_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .SHAMT_W    (SHAMT_W),
            .LVL_LO     (LO),
            .LVL_HI     (HI)
        ) u_stage (
            .clk         (clk),
            .resetn      (resetn),
            .in_valid    (valid_s[k]),
            .in_ready    (ready_s[k]),
            .in_data     (data_s[k]),
            .in_shamt    (shamt_s[k]),
            .in_op       (op_s[k]),
            .in_sign     (sign_s[k]),
            .in_illegal  (illegal_s[k]),
            .out_valid   (valid_s[k+1]),
            .out_ready   (ready_s[k+1]),
            .out_data    (data_s[k+1]),
            .out_shamt   (shamt_s[k+1]),
            .out_op      (op_s[k+1]),
            .out_sign    (sign_s[k+1]),
            .out_illegal (illegal_s[k+1])
        );
    end

    // Upper amount bits and the final stage's side-band are deliberately dropped.
    logic sideband_unused;
    assign sideband_unused = ^{B[DATA_WIDTH-1:SHAMT_W], shamt_s[NUM_STAGES],
                               op_s[NUM_STAGES], sign_s[NUM_STAGES]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Randomised and directed bench for pipelined_shifter across several widths
// and stage depths, scored against an arithmetic reference model.
module tb_pipelined_shifter;

    localparam int NCFG        = 4;
    localparam int MAIN_STAGES = 3;

    typedef struct packed {
        logic [63:0] res;
        logic        ill;
        logic        lit_en;
        logic [63:0] lit_res;
        logic        lit_ill;
        logic        lat_en;
        int          acc_cyc;
    } exp_t;

    function automatic int cfg_w(input int i);
        case (i)
            0:       return 32;
            1:       return 8;
            2:       return 64;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_l(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 6;
            default: return 3;
        endcase
    endfunction

    // Result of shifting the low w bits of a by (b mod w); bit 64 flags an illegal op.
    function automatic logic [64:0] model(input int w, input logic [2:0] op,
                                          input logic [63:0] a_full, input logic [63:0] b_full);
        logic [63:0] mask, a, r;
        int s;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        a    = a_full & mask;
        s    = int'(b_full[31:0]) & (w - 1);
        case (op)
            3'b000:  r = (a << s) & mask;
            3'b010:  r = a >> s;
            3'b011:  r = (a >> s) | (a[w-1] ? (mask & ~(mask >> s)) : 64'd0);
            3'b100:  r = ((a << s) | (a >> (w - s))) & mask;
            3'b101:  r = ((a >> s) | (a << (w - s))) & mask;
            default: return {1'b1, 64'd0};
        endcase
        return {1'b0, r};
    endfunction

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] a_in = '0;
    logic [63:0] b_in = '0;
    logic [2:0]  shiftop = '0;
    logic        out_ready;
    logic        dir_rdy = 1'b1;
    logic        rnd_rdy = 1'b1;
    logic        rand_rdy_en = 1'b0;

    logic        tag_lit_en = 1'b0;
    logic [63:0] tag_lit_res = '0;
    logic        tag_lit_ill = 1'b0;
    logic        tag_lat_en = 1'b0;
    logic        exp_rdy_en = 1'b0;
    logic        exp_rdy = 1'b0;
    logic        final_chk = 1'b0;

    logic        ir  [NCFG];
    logic        ov  [NCFG];
    logic [63:0] res [NCFG];
    logic        ill [NCFG];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    exp_t        exp_q [NCFG][$];
    logic        prev_hold [NCFG];
    logic [63:0] prev_res  [NCFG];
    logic        prev_ill  [NCFG];
    logic        head_seen [NCFG];

    assign out_ready = rand_rdy_en ? rnd_rdy : dir_rdy;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int W = cfg_w(g);
        localparam int L = cfg_l(g);
        logic [W-1:0] r;
        pipelined_shifter #(
            .DATA_WIDTH       (W),
            .LEVELS_PER_STAGE (L)
        ) u_dut (
            .clk         (clk),
            .resetn      (resetn),
            .in_valid    (in_valid),
            .in_ready    (ir[g]),
            .A           (a_in[W-1:0]),
            .B           (b_in[W-1:0]),
            .Shiftop     (shiftop),
            .out_valid   (ov[g]),
            .out_ready   (out_ready),
            .Result      (r),
            .out_illegal (ill[g])
        );
        assign res[g] = 64'(r);
    end

    task automatic check(input bit ok, input string name, input int d,
                         input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, want %h (cycle %0d)", name, d, act, want, cyc);
        end
    endtask

    // Single compare process: scoreboard per DUT, reset state, stability and pinned values.
    always @(negedge clk) begin
        exp_t        e;
        logic [64:0] m;
        cyc++;
        for (int d = 0; d < NCFG; d++) begin
            if (!resetn) begin
                check(res[d] == 64'd0, "reset_result", d, res[d], 64'd0);
                check({ov[d], ill[d], ir[d]} == 3'b001, "reset_flags", d,
                      {61'd0, ov[d], ill[d], ir[d]}, 64'd1);
                exp_q[d].delete();
                prev_hold[d] = 1'b0;
                head_seen[d] = 1'b0;
            end else begin
                if (prev_hold[d]) begin
                    check(ov[d] && res[d] == prev_res[d] && ill[d] == prev_ill[d],
                          "hold_stable", d, res[d], prev_res[d]);
                end
                if (exp_q[d].size() == 0) begin
                    check(!ov[d], "no_spurious_valid", d, {63'd0, ov[d]}, 64'd0);
                end else if (ov[d]) begin
                    if (!head_seen[d]) begin
                        head_seen[d] = 1'b1;
                        if (exp_q[d][0].lat_en) begin
                            check(cyc - exp_q[d][0].acc_cyc == MAIN_STAGES, "latency", d,
                                  64'(cyc - exp_q[d][0].acc_cyc), 64'(MAIN_STAGES));
                        end
                    end
                    if (out_ready) begin
                        e = exp_q[d].pop_front();
                        head_seen[d] = 1'b0;
                        check(res[d] == e.res, "result", d, res[d], e.res);
                        check(ill[d] == e.ill, "out_illegal", d, {63'd0, ill[d]}, {63'd0, e.ill});
                        if (e.lit_en) begin
                            check(res[d] == e.lit_res, "pinned_result", d, res[d], e.lit_res);
                            check(ill[d] == e.lit_ill, "pinned_illegal", d,
                                  {63'd0, ill[d]}, {63'd0, e.lit_ill});
                        end
                    end
                end
                prev_hold[d] = ov[d] && !out_ready;
                prev_res[d]  = res[d];
                prev_ill[d]  = ill[d];
                if (in_valid && ir[d]) begin
                    m         = model(cfg_w(d), shiftop, a_in, b_in);
                    e.res     = m[63:0];
                    e.ill     = m[64];
                    e.lit_en  = (d == 0) && tag_lit_en;
                    e.lit_res = tag_lit_res;
                    e.lit_ill = tag_lit_ill;
                    e.lat_en  = (d == 0) && tag_lat_en;
                    e.acc_cyc = cyc;
                    exp_q[d].push_back(e);
                end
            end
        end
        if (resetn && exp_rdy_en) begin
            check(ir[0] == exp_rdy, "in_ready", 0, {63'd0, ir[0]}, {63'd0, exp_rdy});
        end
        if (final_chk) begin
            for (int d = 0; d < NCFG; d++) begin
                check(exp_q[d].size() == 0, "drained", d, 64'(exp_q[d].size()), 64'd0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input bit lit, input logic [63:0] lres, input bit lill, input bit lat);
        shiftop     = op;
        a_in        = a;
        b_in        = b;
        tag_lit_en  = lit;
        tag_lit_res = lres;
        tag_lit_ill = lill;
        tag_lat_en  = lat;
        in_valid    = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (ir[0]) break;
            if (t >= 200) begin
                $display("FAIL send_timeout dut0: got no in_ready for %0d cycles, want accept", t);
                $fatal(1, "send timed out");
            end
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        tag_lit_en = 1'b0;
        tag_lat_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog dut0: got no completion, want $finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] b_r;
        bit          drained;

        // Reset, then in_ready must be high on the first cycle out of reset.
        repeat (3) @(posedge clk);
        #1;
        resetn     = 1'b1;
        exp_rdy_en = 1'b1;
        exp_rdy    = 1'b1;
        idle(1);
        exp_rdy_en = 1'b0;

        // Single SRA with exact latency.
        send(3'b011, 64'h8000_00F0, 64'd4, 1, 64'hF800_000F, 0, 1);
        idle(6);

        // Back-to-back ROR.
        send(3'b101, 64'h1, 64'd1,  1, 64'h8000_0000, 0, 1);
        send(3'b101, 64'h1, 64'd2,  1, 64'h4000_0000, 0, 1);
        send(3'b101, 64'h1, 64'd3,  1, 64'h2000_0000, 0, 1);
        send(3'b101, 64'h1, 64'd31, 1, 64'h0000_0002, 0, 1);
        idle(6);

        // Back-pressure: three accepts fill the pipe, then in_ready drops.
        dir_rdy = 1'b0;
        send(3'b100, 64'h8000_0001, 64'd4,  1, 64'h0000_0018, 0, 0);
        send(3'b010, 64'hF000_0000, 64'd28, 1, 64'h0000_000F, 0, 0);
        send(3'b000, 64'h0000_00AB, 64'd8,  1, 64'h0000_AB00, 0, 0);
        exp_rdy_en = 1'b1;
        exp_rdy    = 1'b0;
        idle(1);
        exp_rdy_en = 1'b0;
        idle(4);
        dir_rdy = 1'b1;
        idle(6);

        // Boundary amounts and an illegal op.
        send(3'b000, 64'hFFFF_FFFF, 64'd32, 1, 64'hFFFF_FFFF, 0, 1);
        send(3'b111, 64'h1234_5678, 64'd5,  1, 64'h0,         1, 1);
        send(3'b000, 64'hDEAD_BEEF, 64'd0,  1, 64'hDEAD_BEEF, 0, 0);
        send(3'b010, 64'hDEAD_BEEF, 64'd0,  1, 64'hDEAD_BEEF, 0, 0);
        send(3'b011, 64'hDEAD_BEEF, 64'd64, 1, 64'hDEAD_BEEF, 0, 0);
        send(3'b100, 64'hDEAD_BEEF, 64'd0,  1, 64'hDEAD_BEEF, 0, 0);
        send(3'b101, 64'hDEAD_BEEF, 64'd0,  1, 64'hDEAD_BEEF, 0, 0);
        send(3'b001, 64'hDEAD_BEEF, 64'd3,  1, 64'h0,         1, 0);
        idle(6);

        // Reset with requests in flight: nothing may emerge afterwards.
        dir_rdy = 1'b0;
        send(3'b000, 64'h1111, 64'd1, 0, 64'h0, 0, 0);
        send(3'b010, 64'h2222, 64'd2, 0, 64'h0, 0, 0);
        send(3'b101, 64'h3333, 64'd3, 0, 64'h0, 0, 0);
        resetn = 1'b0;
        idle(2);
        resetn  = 1'b1;
        dir_rdy = 1'b1;
        idle(8);
        send(3'b000, 64'h3, 64'd2, 1, 64'hC, 0, 1);
        idle(6);

        // Random traffic with random out_ready.
        rand_rdy_en = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            case ($urandom_range(0, 3))
                0:       b_r = 64'($urandom_range(0, 70));
                1:       b_r = {$urandom, $urandom};
                2:       b_r = 64'd0;
                default: begin
                    case ($urandom_range(0, 3))
                        0:       b_r = 64'd31;
                        1:       b_r = 64'd32;
                        2:       b_r = 64'd63;
                        default: b_r = 64'd64;
                    endcase
                end
            endcase
            send(3'($urandom_range(0, 7)), {$urandom, $urandom}, b_r, 0, 64'h0, 0, 0);
        end
        rand_rdy_en = 1'b0;
        dir_rdy     = 1'b1;

        for (int t = 0; t < 100; t++) begin
            drained = 1'b1;
            for (int d = 0; d < NCFG; d++) begin
                if (exp_q[d].size() != 0) drained = 1'b0;
            end
            if (drained) break;
            idle(1);
        end
        final_chk = 1'b1;
        idle(1);
        final_chk = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
